id_ex_operand_stage: RTL

Pipeline register between register read and execute. It captures the two operands read from the register file and applies forwarding from the execute and writeback stages. It detects load-use hazards, inserting a one-cycle bubble for each, and presents registered operands, destination and control to the ALU stage. A saturating bubble counter supports performance debug.

---
 rtl/id_ex_operand_stage.sv | 125 ++++++++++++
 1 files changed

// File: rtl/id_ex_operand_stage.sv
`default_nettype none
// ============================================================================
// id_ex_operand_stage : ID/EX pipeline register with EX/WB operand forwarding,
//                       load-use bubble insertion and a saturating bubble count
// Revision: 1.0
// ============================================================================
module id_ex_operand_stage #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [3:0]       rn_idx,
  input  logic [3:0]       rm_idx,
  input  logic [3:0]       rd_idx,
  input  logic [WIDTH-1:0] rn_data,
  input  logic [WIDTH-1:0] rm_data,
  input  logic [WIDTH-1:0] imm,
  input  logic             use_imm,
  input  logic             reg_write,
  input  logic             link,
  input  logic             is_load,
  input  logic             stall,
  input  logic             flush,
  input  logic             ex_wr_en,
  input  logic [3:0]       ex_wr_dest,
  input  logic [WIDTH-1:0] ex_wr_data,
  input  logic             ex_is_load,
  input  logic             wb_wr_en,
  input  logic [3:0]       wb_wr_dest,
  input  logic [WIDTH-1:0] wb_wr_data,
  output logic             hazard_stall,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_op_a,
  output logic [WIDTH-1:0] out_op_b,
  output logic [3:0]       out_rd,
  output logic             out_reg_write,
  output logic             out_link,
  output logic             out_is_load,
  output logic [CNT_W-1:0] bubble_count
);

  localparam logic [3:0] C_PC_IDX = 4'd15;

  logic             valid_q;
  logic [WIDTH-1:0] op_a_q, op_b_q;
  logic [3:0]       rd_q;
  logic             reg_write_q, link_q, is_load_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] op_a_d, op_b_d;
  logic             haz_d;

  // Register 15 reads as the PC, so it is never a forwarding target.
  always_comb begin
    op_a_d = rn_data;
    if (ex_wr_en && (ex_wr_dest == rn_idx) && (rn_idx != C_PC_IDX)) begin
      op_a_d = ex_wr_data;
    end else if (wb_wr_en && (wb_wr_dest == rn_idx) && (rn_idx != C_PC_IDX)) begin
      op_a_d = wb_wr_data;
    end
  end

  always_comb begin
    op_b_d = rm_data;
    if (use_imm) begin
      op_b_d = imm;
    end else if (ex_wr_en && (ex_wr_dest == rm_idx) && (rm_idx != C_PC_IDX)) begin
      op_b_d = ex_wr_data;
    end else if (wb_wr_en && (wb_wr_dest == rm_idx) && (rm_idx != C_PC_IDX)) begin
      op_b_d = wb_wr_data;
    end
  end

  always_comb begin
    haz_d = in_valid && ex_wr_en && ex_is_load && (ex_wr_dest != C_PC_IDX) &&
            ((ex_wr_dest == rn_idx) || (!use_imm && (ex_wr_dest == rm_idx))) &&
            !flush;
  end

  always_comb begin
    cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q     <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
      link_q      <= 1'b0;
      is_load_q   <= 1'b0;
      cnt_q       <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (stall) begin
      valid_q <= valid_q;
    end else if (haz_d) begin
      valid_q <= 1'b0;
      cnt_q   <= cnt_d;
    end else begin
      valid_q     <= in_valid;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      rd_q        <= rd_idx;
      reg_write_q <= in_valid & reg_write;
      link_q      <= in_valid & link;
      is_load_q   <= in_valid & is_load;
    end
  end

  assign hazard_stall  = haz_d;
  assign out_valid     = valid_q;
  assign out_op_a      = op_a_q;
  assign out_op_b      = op_b_q;
  assign out_rd        = rd_q;
  assign out_reg_write = reg_write_q;
  assign out_link      = link_q;
  assign out_is_load   = is_load_q;
  assign bubble_count  = cnt_q;

endmodule
`default_nettype wire
